// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the systolic MAC array, its operand
// feeders and tpumac.
package tpu_pkg;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;

  typedef logic signed [BITS_AB-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/feeder_skew_sel.sv
// Per-row skew picker: array row ROW sees element (cnt - ROW) of its buffered
// row while that index lies inside the row, and zero padding otherwise.
module feeder_skew_sel
  import tpu_pkg::*;
#(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM,
  parameter int ROW     = 0,
  parameter int CW      = $clog2(2*DIM)
) (
  input  logic [CW-1:0]          cnt,
  input  logic [DIM*BITS_AB-1:0] row_data,
  output logic [BITS_AB-1:0]     elem
);

  // select element j when cnt == ROW + j; no match means padding
  always_comb begin
    elem = '0;
    for (int j = 0; j < DIM; j++) begin
      if (int'(cnt) == ROW + j) elem = row_data[j*BITS_AB +: BITS_AB];
    end
  end

endmodule

// File: rtl/systolic_a_feeder.sv
// West-edge operand feeder for the systolic MAC array. Buffers one DIM x DIM
// matrix, then streams it as a diagonal wavefront (row i delayed i cycles).
// Optional build macro: FEEDER_TRANSPOSE_EN (load_idx addresses a column).
//
// Load handshake: a vector is written when load_valid && load_ready && en at a
// rising clk edge; load_ready is high only in IDLE and does not depend on
// load_valid. Nothing is written when en=0.
module systolic_a_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = tpu_pkg::BITS_AB,
  parameter int DIM     = tpu_pkg::DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DIM)-1:0]   load_idx,
  input  logic [DIM*BITS_AB-1:0]   load_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     a_valid,
  output logic [DIM*BITS_AB-1:0]   a_out,
  output feeder_state_t            state_dbg
);

  localparam int W  = DIM*BITS_AB;
  localparam int CW = $clog2(2*DIM);
  localparam logic [CW-1:0] LAST = CW'(2*DIM-2);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_out_q, a_out_d;
  logic          a_valid_q, a_valid_d;
  logic          done_q, done_d;
  logic [DIM-1:0][W-1:0] buf_q, buf_d;
  logic [CW-1:0] sel_t;
  logic [W-1:0]  slice_w;

  // buffer write; slices are built from buf_d so a load paired with start is seen at once
  always_comb begin
    buf_d = buf_q;
    if (en && state_q == IDLE && load_valid && (int'(load_idx) < DIM)) begin
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
`ifdef FEEDER_TRANSPOSE_EN
          if (int'(load_idx) == j) buf_d[i][j*BITS_AB +: BITS_AB] = load_data[i*BITS_AB +: BITS_AB];
`else
          if (int'(load_idx) == i) buf_d[i][j*BITS_AB +: BITS_AB] = load_data[j*BITS_AB +: BITS_AB];
`endif
        end
      end
    end
  end

  // IDLE prepares slice(0) for start; STREAM prepares slice(cnt+1)
  assign sel_t = (state_q == IDLE) ? '0 : cnt_q + CW'(1);

  for (genvar i = 0; i < DIM; i++) begin : g_row
    feeder_skew_sel #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROW     (i),
      .CW      (CW)
    ) u_sel (
      .cnt      (sel_t),
      .row_data (buf_d[i]),
      .elem     (slice_w[i*BITS_AB +: BITS_AB])
    );
  end

  // next-state and output register values; en=0 holds everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_out_d   = a_out_q;
    a_valid_d = a_valid_q;
    done_d    = done_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = STREAM;
            cnt_d     = '0;
            a_out_d   = slice_w;
            a_valid_d = 1'b1;
          end
        end
        STREAM: begin
          if (cnt_q == LAST) begin
            state_d   = DONE;
            a_out_d   = '0;
            a_valid_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            a_out_d = slice_w;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // control and output registers; reset returns to IDLE mid-stream too
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_out_q   <= '0;
      a_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_out_q   <= a_out_d;
      a_valid_q <= a_valid_d;
      done_q    <= done_d;
    end
  end

  // operand buffer survives reset so a later start replays it
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign a_valid    = a_valid_q;
  assign a_out      = a_out_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Bench for systolic_a_feeder (DIM=8, BITS_AB=8). Honours FEEDER_TRANSPOSE_EN.
module tb_systolic_a_feeder;
  import tpu_pkg::*;

  localparam int N = 8;
  localparam int B = 8;
  localparam int W = N*B;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load_valid = 1'b0;
  logic start = 1'b0;
  logic [2:0] load_idx = '0;
  logic [W-1:0] load_data = '0;
  logic load_ready, busy, done, a_valid;
  logic [W-1:0] a_out;
  feeder_state_t state_dbg;

  always #5 clk = ~clk;

  systolic_a_feeder #(.BITS_AB(B), .DIM(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_idx   (load_idx),
    .load_data  (load_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .a_valid    (a_valid),
    .a_out      (a_out),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic en_prev = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [7:0] mdl [N][N];

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] slice_f(int t);
    logic [W-1:0] r;
    int d;
    r = '0;
    for (int i = 0; i < N; i++) begin
      d = t - i;
      if (d >= 0 && d < N) r[i*B +: B] = mdl[i][d];
    end
    return r;
  endfunction

  task automatic push_stream();
    for (int t = 0; t < 2*N-1; t++) exp_q.push_back(slice_f(t));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) en_prev <= en;

  always @(negedge clk) begin
    if (a_valid === 1'b1 && en_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_slice actual=%h required=no a_valid", a_out);
      end else begin
        chk("slice", a_out, exp_q.pop_front());
      end
    end
    if (done === 1'b1 && en_prev) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic load_vec(int idx, logic [W-1:0] data, bit with_start);
    load_valid = 1'b1;
    load_idx   = 3'(idx);
    load_data  = data;
    start      = with_start;
    for (int j = 0; j < N; j++) begin
`ifdef FEEDER_TRANSPOSE_EN
      mdl[j][idx] = data[j*B +: B];
`else
      mdl[idx][j] = data[j*B +: B];
`endif
    end
    if (with_start) push_stream();
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic start_stream();
    start = 1'b1;
    push_stream();
    @(negedge clk);
    start = 1'b0;
  endtask

  // waits (bounded) for done counting cycles from c0, then checks the idle cycle after
  task automatic wait_done(int c0, int exp_c, string name);
    int c;
    c = c0;
    while (done !== 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk(name, W'(c), W'(exp_c));
    @(negedge clk);
    chk({name, "_idle_ready"}, W'(load_ready), W'(1));
    chk({name, "_idle_busy"}, W'(busy), W'(0));
    chk({name, "_drained"}, W'(exp_q.size()), W'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [W-1:0] d;
    int d0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) mdl[i][j] = '0;

    // reset
    rst_n = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_a_out", a_out, '0);
    chk("rst_a_valid", W'(a_valid), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_load_ready", W'(load_ready), W'(1));
    chk("rst_state", W'(state_dbg), W'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: load buf[i][j] = i*8+j+1, stream it
    for (int i = 0; i < N; i++) begin
      chk("t1_load_ready", W'(load_ready), W'(1));
      for (int j = 0; j < N; j++) begin
`ifdef FEEDER_TRANSPOSE_EN
        d[j*B +: B] = 8'(j*8 + i + 1);
`else
        d[j*B +: B] = 8'(i*8 + j + 1);
`endif
      end
      load_vec(i, d, 1'b0);
    end
    d0 = done_cnt;
    start_stream();
    chk("t1_c0", a_out, 64'h0000_0000_0000_0001);
    @(negedge clk);
    chk("t1_c1", a_out, 64'h0000_0000_0000_0902);
    repeat (13) @(negedge clk);
    chk("t1_c14", a_out, 64'h4000_0000_0000_0000);
    wait_done(14, 15, "t1_done_cycle");
    chk("t1_done_pulses", W'(done_cnt - d0), W'(1));

    // 2: stall 3 cycles at cycle 5, loads in STREAM ignored
    start_stream();
    repeat (5) @(negedge clk);
    en = 1'b0;
    load_valid = 1'b1;
    load_idx = 3'd1;
    load_data = {W{1'b1}};
    repeat (3) begin
      @(negedge clk);
      chk("t2_frozen", a_out, slice_f(5));
    end
    en = 1'b1;
    load_idx = 3'd0;
    @(negedge clk);
    chk("t2_load_ready_stream", W'(load_ready), W'(0));
    load_valid = 1'b0;
    wait_done(9, 18, "t2_done_cycle");

    // 3: reset mid-stream, buffer retained
    start_stream();
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t3_rst_a_out", a_out, '0);
    chk("t3_rst_a_valid", W'(a_valid), W'(0));
    chk("t3_rst_busy", W'(busy), W'(0));
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    start_stream();
    chk("t3_replay_c0", a_out, 64'h0000_0000_0000_0001);
    wait_done(0, 15, "t3_done_cycle");

    // 4: signed extremes loaded with start in the same cycle
    load_vec(0, 64'h0000_0000_00FF_7F80, 1'b1);
    chk("t4_c0_row0", W'(a_out[7:0]), W'(8'h80));
    @(negedge clk);
`ifdef FEEDER_TRANSPOSE_EN
    chk("t4_c1_row1", W'(a_out[15:8]), W'(8'h7F));
`else
    chk("t4_c1_row0", W'(a_out[7:0]), W'(8'h7F));
`endif
    wait_done(1, 15, "t4_done_cycle");

    // 5: start pulses in STREAM and DONE are ignored
    d0 = done_cnt;
    start_stream();
    for (int c = 0; c < 18; c++) begin
      start = (c == 3 || c == 15);
      if (c == 15) chk("t5_done_at15", W'(done), W'(1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_one_done", W'(done_cnt - d0), W'(1));
    chk("t5_idle_busy", W'(busy), W'(0));
    chk("t5_drained", W'(exp_q.size()), W'(0));

`ifdef FEEDER_TRANSPOSE_EN
    // 6: column load, element j -> buf[j][2]
    load_vec(2, 64'h0807_0605_0403_0201, 1'b0);
    start_stream();
    for (int c = 0; c < 9; c++) begin
      if (c == 2) chk("t6_c2_row0", W'(a_out[7:0]), W'(8'd1));
      if (c == 3) chk("t6_c3_row1", W'(a_out[15:8]), W'(8'd2));
      @(negedge clk);
    end
    chk("t6_c9_row7", W'(a_out[63:56]), W'(8'd8));
    wait_done(9, 15, "t6_done_cycle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
